// File: rtl/ttw_pkg.sv
// Shared types and helpers for the translation-walker memory arbiter.
package ttw_pkg;

  localparam int TTW_MAX_OUT = 4;

  function automatic int ttw_src_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [6:0]  idx;
    logic [63:0] mcn;
  } ttw_mem_req_t;

  typedef struct packed {
    logic [6:0]   idx;
    logic [511:0] data;
  } ttw_mem_res_t;

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin picker: first eligible after ptr wins.
module rr_arb #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_s;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_s   = 0;
    for (int k = 1; k <= N; k++) begin
      w_s = (int'(i_ptr) + k) % N;
      if (!o_any && i_elig[w_s]) begin
        o_any      = 1'b1;
        o_gnt[w_s] = 1'b1;
        o_idx      = PW'(w_s);
      end
    end
  end

endmodule

// File: rtl/ttw_mem_arb.sv
// Shares the walker memory port between NREQ walkers with
// round-robin grant, per-source credits and tag-routed responses.
module ttw_mem_arb
  import ttw_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDX_W   = 6,
  parameter int MCN_W   = 64,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = TTW_MAX_OUT,
  localparam int SRC_W  = ttw_src_w(NREQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_i_valid,
  output logic [NREQ-1:0]        req_i_ready,
  input  logic [NREQ*IDX_W-1:0]  req_i_bits_idx,
  input  logic [NREQ*MCN_W-1:0]  req_i_bits_mcn,
  output logic [NREQ-1:0]        res_o_valid,
  input  logic [NREQ-1:0]        res_o_ready,
  output logic [IDX_W-1:0]       res_o_bits_idx,
  output logic [DATA_W-1:0]      res_o_bits_data,
  input  logic                   mem_req_o_ready,
  output logic                   mem_req_o_valid,
  output logic [SRC_W+IDX_W-1:0] mem_req_o_bits_idx,
  output logic [MCN_W-1:0]       mem_req_o_bits_mcn,
  output logic                   mem_res_i_ready,
  input  logic                   mem_res_i_valid,
  input  logic [SRC_W+IDX_W-1:0] mem_res_i_bits_idx,
  input  logic [DATA_W-1:0]      mem_res_i_bits_data,
  output logic [NREQ-1:0]        busy_o
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic                   r_vld;
  logic [SRC_W+IDX_W-1:0] r_idx;
  logic [MCN_W-1:0]       r_mcn;
  logic [SRC_W-1:0]       r_ptr;
  logic [CW-1:0]          r_cnt [NREQ];

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  logic [NREQ-1:0]  w_dec;
  logic [SRC_W-1:0] w_gidx;
  logic [SRC_W-1:0] w_rsrc;
  logic             w_any;
  logic             w_free;
  logic             w_rsrc_ok;

  assign w_free = ~r_vld | mem_req_o_ready;

  always_comb begin
    w_elig = '0;
    for (int s = 0; s < NREQ; s++)
      w_elig[s] = req_i_valid[s] & w_free &
                  (r_cnt[s] < CW'(MAX_OUT));
  end

  rr_arb #(.N(NREQ), .PW(SRC_W)) u_rr (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );

  assign req_i_ready = w_gnt;

  assign w_rsrc    = mem_res_i_bits_idx[IDX_W +: SRC_W];
  assign w_rsrc_ok = int'(w_rsrc) < NREQ;

  // Out-of-range tags match no source, so they are never acked.
  always_comb begin
    res_o_valid     = '0;
    mem_res_i_ready = 1'b0;
    w_dec           = '0;
    for (int s = 0; s < NREQ; s++) begin
      if (int'(w_rsrc) == s) begin
        res_o_valid[s]  = mem_res_i_valid;
        mem_res_i_ready = res_o_ready[s];
        w_dec[s]        = mem_res_i_valid & res_o_ready[s];
      end
    end
  end

  assign res_o_bits_idx  = mem_res_i_bits_idx[IDX_W-1:0];
  assign res_o_bits_data = mem_res_i_bits_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_idx <= '0;
      r_mcn <= '0;
      r_ptr <= SRC_W'(NREQ - 1);
    end else if (w_free) begin
      if (w_any) begin
        r_vld <= 1'b1;
        r_idx <= {w_gidx,
                  req_i_bits_idx[int'(w_gidx)*IDX_W +: IDX_W]};
        r_mcn <= req_i_bits_mcn[int'(w_gidx)*MCN_W +: MCN_W];
        r_ptr <= w_gidx;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NREQ; s++) r_cnt[s] <= '0;
    end else begin
      for (int s = 0; s < NREQ; s++) begin
        if (w_gnt[s] && !w_dec[s])
          r_cnt[s] <= r_cnt[s] + 1'b1;
        else if (w_dec[s] && !w_gnt[s] && r_cnt[s] != '0)
          r_cnt[s] <= r_cnt[s] - 1'b1;
      end
    end
  end

  assign mem_req_o_valid    = r_vld;
  assign mem_req_o_bits_idx = r_idx;
  assign mem_req_o_bits_mcn = r_mcn;

  always_comb begin
    busy_o = '0;
    for (int s = 0; s < NREQ; s++) busy_o[s] = r_cnt[s] != '0;
  end

  a_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(req_i_ready));

  a_hold: assert property (@(posedge clock) disable iff (!reset)
    (r_vld && !mem_req_o_ready) |=>
    (r_vld && $stable(r_idx) && $stable(r_mcn)));

  a_src: assert property (@(posedge clock) disable iff (!reset)
    mem_res_i_valid |-> w_rsrc_ok);

  a_credit: assert property (@(posedge clock) disable iff (!reset)
    (mem_res_i_valid && mem_res_i_ready) |-> |(w_dec & busy_o));

  for (genvar s = 0; s < NREQ; s++) begin : g_cnt_chk
    a_cnt: assert property (@(posedge clock) disable iff (!reset)
      r_cnt[s] <= CW'(MAX_OUT));
  end

endmodule

// File: tb/tb_ttw_mem_arb.sv
// Randomized and directed checks of ttw_mem_arb against a cycle model.
module tb_ttw_mem_arb;

  localparam int NREQ    = 2;
  localparam int IDX_W   = 6;
  localparam int MCN_W   = 64;
  localparam int DATA_W  = 512;
  localparam int MAX_OUT = 4;
  localparam int SRC_W   = 1;
  localparam int IW      = SRC_W + IDX_W;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req_i_valid;
  logic [NREQ-1:0]       req_i_ready;
  logic [NREQ*IDX_W-1:0] req_i_bits_idx;
  logic [NREQ*MCN_W-1:0] req_i_bits_mcn;
  logic [NREQ-1:0]       res_o_valid;
  logic [NREQ-1:0]       res_o_ready;
  logic [IDX_W-1:0]      res_o_bits_idx;
  logic [DATA_W-1:0]     res_o_bits_data;
  logic                  mem_req_o_ready;
  logic                  mem_req_o_valid;
  logic [IW-1:0]         mem_req_o_bits_idx;
  logic [MCN_W-1:0]      mem_req_o_bits_mcn;
  logic                  mem_res_i_ready;
  logic                  mem_res_i_valid;
  logic [IW-1:0]         mem_res_i_bits_idx;
  logic [DATA_W-1:0]     mem_res_i_bits_data;
  logic [NREQ-1:0]       busy_o;

  ttw_mem_arb #(
    .NREQ(NREQ), .IDX_W(IDX_W), .MCN_W(MCN_W),
    .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_i_valid(req_i_valid), .req_i_ready(req_i_ready),
    .req_i_bits_idx(req_i_bits_idx),
    .req_i_bits_mcn(req_i_bits_mcn),
    .res_o_valid(res_o_valid), .res_o_ready(res_o_ready),
    .res_o_bits_idx(res_o_bits_idx),
    .res_o_bits_data(res_o_bits_data),
    .mem_req_o_ready(mem_req_o_ready),
    .mem_req_o_valid(mem_req_o_valid),
    .mem_req_o_bits_idx(mem_req_o_bits_idx),
    .mem_req_o_bits_mcn(mem_req_o_bits_mcn),
    .mem_res_i_ready(mem_res_i_ready),
    .mem_res_i_valid(mem_res_i_valid),
    .mem_res_i_bits_idx(mem_res_i_bits_idx),
    .mem_res_i_bits_data(mem_res_i_bits_data),
    .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  int            m_ptr;
  int            m_cnt [NREQ];
  logic          m_vld;
  logic [IW-1:0] m_idx;
  logic [MCN_W-1:0] m_mcn;
  logic [IW-1:0] pend [$];
  int            d_resj;
  logic [NREQ-1:0] obs_rdy;
  logic [NREQ-1:0] obs_resv;
  logic          obs_mrr;

  task automatic chk(input string tag,
                     input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_idx = '0;
    m_mcn = '0;
    m_ptr = NREQ - 1;
    for (int s = 0; s < NREQ; s++) m_cnt[s] = 0;
    pend.delete();
  endtask

  task automatic drive_idle();
    req_i_valid     = '0;
    req_i_bits_idx  = '0;
    req_i_bits_mcn  = '0;
    res_o_ready     = '0;
    mem_req_o_ready = 1'b1;
    mem_res_i_valid = 1'b0;
    mem_res_i_bits_idx  = '0;
    mem_res_i_bits_data = '0;
  endtask

  task automatic set_res(input int j);
    if (j < 0) begin
      mem_res_i_valid = 1'b0;
    end else begin
      mem_res_i_valid    = 1'b1;
      mem_res_i_bits_idx = pend[j];
      d_resj             = j;
      for (int w = 0; w < DATA_W / 32; w++)
        mem_res_i_bits_data[w*32 +: 32] = $urandom();
    end
  endtask

  task automatic step();
    int g;
    int rs;
    logic free;
    logic es;
    logic hs_req;
    logic hs_res;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    logic [NREQ-1:0] eb;
    #1;
    free = !m_vld || mem_req_o_ready;
    g = -1;
    if (free)
      for (int k = 1; k <= NREQ; k++) begin
        int s;
        s = (m_ptr + k) % NREQ;
        if (g < 0 && req_i_valid[s] && m_cnt[s] < MAX_OUT) g = s;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    rs = int'(mem_res_i_bits_idx[IW-1:IDX_W]);
    ev = '0;
    if (mem_res_i_valid) ev[rs] = 1'b1;
    es = res_o_ready[rs];
    eb = '0;
    for (int s = 0; s < NREQ; s++) eb[s] = m_cnt[s] != 0;
    chk("req_rdy", req_i_ready, er);
    chk("res_vld", res_o_valid, ev);
    chk("mres_rdy", mem_res_i_ready, es);
    chk("res_idx", res_o_bits_idx, mem_res_i_bits_idx[IDX_W-1:0]);
    chk("res_data", res_o_bits_data, mem_res_i_bits_data);
    chk("mreq_vld", mem_req_o_valid, m_vld);
    chk("mreq_idx", mem_req_o_bits_idx, m_idx);
    chk("mreq_mcn", mem_req_o_bits_mcn, m_mcn);
    chk("busy", busy_o, eb);
    obs_rdy  = req_i_ready;
    obs_resv = res_o_valid;
    obs_mrr  = mem_res_i_ready;
    hs_req = m_vld && mem_req_o_ready;
    hs_res = mem_res_i_valid && es;
    @(posedge clock);
    if (hs_res) begin
      pend.delete(d_resj);
      m_cnt[rs]--;
    end
    if (hs_req) pend.push_back(m_idx);
    if (g >= 0) begin
      m_cnt[g]++;
      m_vld = 1'b1;
      m_idx = {SRC_W'(g), req_i_bits_idx[g*IDX_W +: IDX_W]};
      m_mcn = req_i_bits_mcn[g*MCN_W +: MCN_W];
      m_ptr = g;
    end else if (free) begin
      m_vld = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    req_i_valid     = '0;
    mem_req_o_ready = 1'b1;
    res_o_ready     = '1;
    for (int i = 0; i < 40 && (pend.size() > 0 || m_vld); i++) begin
      set_res(pend.size() > 0 ? 0 : -1);
      step();
    end
    set_res(-1);
    chk("drain", pend.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    drive_idle();
    model_reset();
    #12;
    chk("rst_vld", mem_req_o_valid, 1'b0);
    chk("rst_idx", mem_req_o_bits_idx, '0);
    chk("rst_mcn", mem_req_o_bits_mcn, '0);
    chk("rst_busy", busy_o, '0);
    @(negedge clock);
    reset = 1'b1;

    req_i_valid    = 2'b01;
    req_i_bits_idx = {6'd0, 6'd5};
    req_i_bits_mcn = {64'd0, 64'h1000};
    step();
    chk("t1_gnt", obs_rdy, 2'b01);
    chk("t1_vld", mem_req_o_valid, 1'b1);
    chk("t1_idx", mem_req_o_bits_idx, 7'h05);
    chk("t1_mcn", mem_req_o_bits_mcn, 64'h1000);
    drain();

    do_reset();
    req_i_valid = 2'b11;
    res_o_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      req_i_bits_idx = NREQ*IDX_W'($urandom());
      set_res(pend.size() > 0 ? 0 : -1);
      step();
      chk("t2_alt", obs_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    drain();

    req_i_valid = 2'b10;
    res_o_ready = 2'b00;
    for (int k = 0; k < 8; k++) step();
    chk("t3_block", obs_rdy, 2'b00);
    chk("t3_busy", busy_o[1], 1'b1);
    res_o_ready = 2'b10;
    set_res(0);
    step();
    set_res(-1);
    step();
    chk("t3_regrant", obs_rdy, 2'b10);
    drain();

    req_i_valid = 2'b01;
    mem_req_o_ready = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      req_i_bits_idx = NREQ*IDX_W'($urandom());
      req_i_bits_mcn = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      chk("t4_hold", obs_rdy, 2'b00);
    end
    mem_req_o_ready = 1'b1;
    step();
    chk("t4_resume", obs_rdy, 2'b01);
    drain();

    req_i_valid    = 2'b10;
    req_i_bits_idx = {6'h2A, 6'h00};
    step();
    req_i_valid = 2'b00;
    step();
    res_o_ready = 2'b00;
    set_res(0);
    step();
    chk("t5_resv", obs_resv, 2'b10);
    chk("t5_mrr", obs_mrr, 1'b0);
    chk("t5_busy", busy_o[1], 1'b1);
    res_o_ready = 2'b10;
    step();
    chk("t5_done", busy_o[1], 1'b0);
    drain();

    req_i_valid = 2'b11;
    step();
    step();
    mem_req_o_ready = 1'b0;
    step();
    #3;
    reset = 1'b0;
    #1;
    chk("t6_vld", mem_req_o_valid, 1'b0);
    chk("t6_busy", busy_o, 2'b00);
    drive_idle();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    req_i_valid = 2'b11;
    step();
    chk("t6_ptr", obs_rdy, 2'b01);

    for (int c = 0; c < 2000; c++) begin
      req_i_valid     = NREQ'($urandom());
      req_i_bits_idx  = NREQ*IDX_W'($urandom());
      req_i_bits_mcn  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_req_o_ready = ($urandom() % 4) != 0;
      res_o_ready     = NREQ'($urandom());
      if (pend.size() > 0 && ($urandom() % 2) == 1)
        set_res($urandom_range(pend.size() - 1, 0));
      else
        set_res(-1);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
